ripple_count_capture: RTL

//  Downstream consumer of the 4-bit ripple counter. Samples the counter's asynchronously settling
//  q bus into the system clock domain and commits a value only once it has been stable for a

---
 rtl/ripple_cnt_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/ripple_count_capture.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ripple_cnt_pkg.sv
// ----------------------------------------------------------------------------
// ripple_cnt_pkg
//  Shared definitions for the ripple counter capture block.
//  - State encoding for the capture FSM (IDLE / SETTLE / HOLD).
//  - next_count(): increment modulo 2^width, used by both the wrap detector
//    and the optional step checker so they agree on what "next" means.
// ----------------------------------------------------------------------------
package ripple_cnt_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    HOLD   = ST_HOLD
  } state_t;

  // Increment modulo 2^width; callers truncate the result to their bus width.
  function automatic logic [31:0] next_count(input logic [31:0] value,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
//  Two-flop synchroniser for a WIDTH-bit bus. Each bit is synchronised
//  independently; multi-bit coherence is restored downstream by requiring
//  the synchronised value to be stable for several cycles.
// Ports
//  clk    in   1      destination clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  d      in   WIDTH  asynchronous input bus
//  q      out  WIDTH  synchronised bus (2 cycles latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// ----------------------------------------------------------------------------
// ripple_count_capture
//  Captures the output of an asynchronous ripple counter into the clk domain.
//  The bus is synchronised, then a value is committed to cnt_out only after
//  it has been seen unchanged for STABLE_CYCLES consecutive samples, so ripple
//  glitches never propagate. Each commit gives a one-cycle cnt_valid pulse;
//  max->0 commits are counted as wraps in a saturating counter.
// Ports
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous active-low reset
//  cnt_in      in   WIDTH   raw ripple counter bus (asynchronous)
//  clear       in   1       synchronous clear of wrap_count, wrap_sat, step_err
//  cnt_out     out  WIDTH   last committed stable value
//  cnt_valid   out  1       one-cycle pulse when cnt_out is updated
//  wrap_pulse  out  1       one-cycle pulse with cnt_valid on a max->0 commit
//  wrap_count  out  WRAP_W  saturating wrap counter
//  wrap_sat    out  1       sticky, wrap_count reached all-ones
//  step_err    out  1       sticky, non-incrementing commit seen
// Configuration
//  RIPPLE_STEP_CHECK_EN : when defined, builds the step checker driving
//  step_err; otherwise step_err is constant 0.
// ----------------------------------------------------------------------------
module ripple_count_capture
  import ripple_cnt_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clear,
  output logic [WIDTH-1:0]  cnt_out,
  output logic              cnt_valid,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_sat,
  output logic              step_err
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0]  s2;
  logic [WIDTH-1:0]  cand;
  logic [WIDTH-1:0]  cand_nxt;
  logic [SW-1:0]     stab_cnt;
  logic [SW-1:0]     stab_nxt;
  logic [1:0]        fill;
  logic              stable;
  state_t            state;
  state_t            state_nxt;
  logic              commit;
  logic              first;
  logic [WIDTH-1:0]  cnt_inc;
  logic              wrap_hit;
  logic [WRAP_W-1:0] wrap_count_nxt;

  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (cnt_in),
    .q     (s2)
  );

  // Stability tracking. While the synchroniser is still flushing its reset
  // zeros (fill not yet full) nothing is counted, so the reset value of the
  // sync flops can never be mistaken for a real counter value. Decisions use
  // the next-state values so the commit lands on the edge where the count
  // reaches STABLE_CYCLES.
  always_comb begin
    cand_nxt = s2;
    stab_nxt = '0;
    if (fill[1]) begin
      if (s2 != cand)
        stab_nxt = SW'(1);
      else if (stab_cnt == SW'(STABLE_CYCLES))
        stab_nxt = stab_cnt;
      else
        stab_nxt = stab_cnt + SW'(1);
    end
  end

  assign stable = (stab_nxt == SW'(STABLE_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill     <= '0;
      cand     <= '0;
      stab_cnt <= '0;
      state    <= IDLE;
    end else begin
      fill     <= {fill[0], 1'b1};
      cand     <= cand_nxt;
      stab_cnt <= stab_nxt;
      state    <= state_nxt;
    end
  end

  // Capture FSM. HOLD may commit directly when STABLE_CYCLES is 1, since the
  // new value is already stable on the same edge that reveals the change.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    first     = 1'b0;
    case (state)
      IDLE: begin
        if (stable) begin
          commit    = 1'b1;
          first     = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (s2 != cnt_out) begin
          if (stable)
            commit = 1'b1;
          else
            state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cand_nxt == cnt_out) begin
          state_nxt = HOLD;
        end else if (stable) begin
          commit    = 1'b1;
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A wrap is exactly a commit where the new value is the successor of the
  // old one and that successor is zero.
  assign cnt_inc  = WIDTH'(next_count(32'(cnt_out), WIDTH));
  assign wrap_hit = commit && !first && (cand_nxt == cnt_inc) && (cand_nxt == '0);

  always_comb begin
    wrap_count_nxt = wrap_count;
    if (clear)
      wrap_count_nxt = '0;
    else if (wrap_hit && (wrap_count != '1))
      wrap_count_nxt = wrap_count + WRAP_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_out    <= '0;
      cnt_valid  <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      wrap_sat   <= 1'b0;
    end else begin
      cnt_valid  <= commit;
      wrap_pulse <= wrap_hit;
      wrap_count <= wrap_count_nxt;
      wrap_sat   <= clear ? 1'b0 : (wrap_sat | (&wrap_count_nxt));
      if (commit)
        cnt_out <= cand_nxt;
    end
  end

`ifdef RIPPLE_STEP_CHECK_EN
  logic step_bad;

  assign step_bad = commit && !first && (cand_nxt != cnt_inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      step_err <= 1'b0;
    else if (clear)
      step_err <= 1'b0;
    else if (step_bad)
      step_err <= 1'b1;
  end
`else
  assign step_err = 1'b0;
`endif

endmodule
